// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction encoder: packs opcode/register fields and a 32-bit immediate into an instruction word.
// Optional macro IMM_RANGE_CHECK_EN enables immediate range/alignment rejection; otherwise only bad opcodes are rejected.
module imm_encoder #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    input  logic             err_clear,
    output logic             err_sticky,
    output logic [CNT_W-1:0] enc_count
);

    // Handshake: a word moves across an interface on a rising edge where valid && ready.
    // A holder keeps valid and its data stable until taken; ready never depends on the
    // upstream valid of the same interface beyond the pipeline's own occupancy.

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    fmt_t        in_fmt;
    logic        in_ok;

    logic        s1_valid;
    fmt_t        s1_fmt;
    logic        s1_ok;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s1_adv;
    logic        s2_adv;
    logic        handoff;
    logic [31:0] enc_inst;
    logic        enc_err;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign handoff  = out_valid && out_ready;

    always_comb begin
        in_fmt = FMT_BAD;
        case (in_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: in_fmt = FMT_I;
            7'b0100011:                         in_fmt = FMT_S;
            7'b1100011:                         in_fmt = FMT_B;
            7'b0110111, 7'b0010111:             in_fmt = FMT_U;
            7'b1101111:                         in_fmt = FMT_J;
            7'b0110011:                         in_fmt = FMT_R;
            default:                            in_fmt = FMT_BAD;
        endcase
    end

    // in_ok folds the opcode check in, so stage 2 only needs one reject bit.
    always_comb begin
        in_ok = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        case (in_fmt)
            FMT_I, FMT_S: in_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
            FMT_B:        in_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
            FMT_J:        in_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
            FMT_U:        in_ok = (in_imm[11:0] == 12'd0);
            FMT_R:        in_ok = 1'b1;
            default:      in_ok = 1'b0;
        endcase
`else
        in_ok = (in_fmt != FMT_BAD);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= in_fmt;
                s1_ok     <= in_ok;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_funct7 <= in_funct7;
                s1_imm    <= in_imm;
            end
        end
    end

    always_comb begin
        enc_inst = NOP_INST;
        enc_err  = 1'b1;
        if (s1_ok) begin
            enc_err = 1'b0;
            case (s1_fmt)
                FMT_I: enc_inst = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                FMT_S: enc_inst = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
                FMT_B: enc_inst = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                   s1_imm[4:1], s1_imm[11], s1_opcode};
                FMT_U: enc_inst = {s1_imm[31:12], s1_rd, s1_opcode};
                FMT_J: enc_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                   s1_rd, s1_opcode};
                FMT_R: enc_inst = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
                default: begin
                    enc_inst = NOP_INST;
                    enc_err  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= enc_inst;
                out_err  <= enc_err;
            end
        end
    end

    // A rejection leaving stage 2 outranks a simultaneous clear request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enc_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (handoff && !out_err) enc_count <= enc_count + 1'b1;
            if (handoff && out_err) err_sticky <= 1'b1;
            else if (err_clear)     err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed encodings, stall/reset cases and randomized traffic
// scored against an arithmetic reference model.
module tb_imm_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_opcode = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [2:0]       in_funct3 = '0;
    logic [6:0]       in_funct7 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_inst;
    logic             out_err;
    logic             err_clear = 1'b0;
    logic             err_sticky;
    logic [CNT_W-1:0] enc_count;

    imm_encoder #(.CNT_W(CNT_W), .NOP_INST(32'h00000013)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
        .err_clear(err_clear), .err_sticky(err_sticky), .enc_count(enc_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // reference model: {err, inst} from the instruction-set field layout
    function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
        logic [31:0] base;
        logic [31:0] inst;
        int          s;
        bit          ok;
        bit          bad;
        s    = $signed(imm);
        bad  = 0;
        ok   = 1;
        inst = 32'h13;
        base = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'h13, 7'h03, 7'h67: begin
                ok   = (s >= -2048) && (s <= 2047);
                inst = ((imm & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                     | (32'(rd) << 7) | 32'(op);
            end
            7'h23: begin
                ok   = (s >= -2048) && (s <= 2047);
                inst = base | (((imm >> 5) & 32'h7f) << 25) | ((imm & 32'h1f) << 7);
            end
            7'h63: begin
                ok   = (s >= -4096) && (s <= 4094) && (imm % 2 == 0);
                inst = base | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25)
                     | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7);
            end
            7'h37, 7'h17: begin
                ok   = (imm % 4096) == 0;
                inst = (imm & 32'hfffff000) | (32'(rd) << 7) | 32'(op);
            end
            7'h6f: begin
                ok   = (s >= -1048576) && (s <= 1048574) && (imm % 2 == 0);
                inst = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                     | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12)
                     | (32'(rd) << 7) | 32'(op);
            end
            7'h33: inst = base | (32'(f7) << 25) | (32'(rd) << 7);
            default: bad = 1;
        endcase
`ifndef IMM_RANGE_CHECK_EN
        ok = 1;
`endif
        if (bad || !ok) return {1'b1, 32'h00000013};
        return {1'b0, inst};
    endfunction

    // scoreboard
    logic [32:0]      exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             exp_sticky = 1'b0;
    int               acc_cnt = 0;

    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset) begin
            exp_q.delete();
            exp_cnt    = '0;
            exp_sticky = 1'b0;
        end else begin
            check("enc_count", 32'(enc_count), 32'(exp_cnt));
            check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_valid), 32'd0);
                    if (err_clear) exp_sticky = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("out_inst", out_inst, e[31:0]);
                    check("out_err", 32'(out_err), 32'(e[32]));
                    if (!e[32]) exp_cnt = exp_cnt + 1'b1;
                    if (e[32]) exp_sticky = 1'b1;
                    else if (err_clear) exp_sticky = 1'b0;
                end
            end else if (err_clear) begin
                exp_sticky = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
                acc_cnt++;
            end
        end
    end

    // driver tasks
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int w;
        w         = 0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] exp_inst, input logic exp_err);
        int lat;
        send(op, rd, rs1, rs2, f3, f7, imm);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_inst"}, out_inst, exp_inst);
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        logic [6:0]  ops[10];
        logic [31:0] edges[12];
        logic [31:0] imm;
        ops   = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f};
        edges = '{32'hfffff000, 32'hffffefff, 32'h00000ffe, 32'h00000fff, 32'h000007ff,
                  32'h00000800, 32'hfffff800, 32'hfffff7ff, 32'h000ffffe, 32'h00100000,
                  32'hfff00000, 32'h12345000};
        case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = $urandom_range(0, 4095) - 32'd2048;
            2:       imm = edges[$urandom_range(0, 11)];
            default: imm = $urandom & 32'hfffff000;
        endcase
        send(ops[$urandom_range(0, 9)], 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), imm);
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    bit rnd_on = 0;

    initial begin
        int acc0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        directed("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hffffffff, 32'hfff00093, 1'b0);
        check("addi_count", 32'(enc_count), 32'd1);
        directed("sw",  7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 32'h00512423, 1'b0);
        directed("beq", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hfffffffc, 32'hfe208ee3, 1'b0);
        directed("jal", 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000ef, 1'b0);
        directed("lui", 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123451b7, 1'b0);
        directed("add", 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081b3, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
        directed("addi2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h00000013, 1'b1);
        check("addi2048_sticky", 32'(err_sticky), 32'd1);
        check("addi2048_count", 32'(enc_count), 32'd6);
`else
        directed("addi2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b0);
        check("addi2048_sticky", 32'(err_sticky), 32'd0);
        check("addi2048_count", 32'(enc_count), 32'd7);
`endif
        directed("badop", 7'h7f, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd4, 32'h00000013, 1'b1);
        check("badop_sticky", 32'(err_sticky), 32'd1);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        check("clear_sticky", 32'(err_sticky), 32'd0);
        err_clear = 1'b1;
        directed("setwins", 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);
        check("setwins_sticky", 32'(err_sticky), 32'd1);
        err_clear = 1'b0;

        // stall: four requests against a blocked consumer
        out_ready = 1'b0;
        acc0 = acc_cnt;
        fork
            for (int i = 0; i < 4; i++) send(7'h13, 5'(i + 1), 5'd4, 5'd0, 3'd0, 7'd0, 32'(i * 16));
        join_none
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_accepts", 32'(acc_cnt - acc0), 32'd2);
            check("stall_hold", out_inst, exp_q[0][31:0]);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain("stall");
        check("stall_total", 32'(acc_cnt - acc0), 32'd4);

        // reset with two words in flight
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 2; i++) send(7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i) << 12);
        join_none
        wait fork;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(enc_count), 32'd0);
        check("mid_rst_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk);
        #1;
        directed("post_rst", 7'h13, 5'd2, 5'd3, 5'd0, 3'd7, 7'd0, 32'd5, 32'h0051f113, 1'b0);
        check("post_rst_count", 32'(enc_count), 32'd1);

        // randomized traffic with random backpressure and clears
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
                err_clear = ($urandom_range(0, 15) == 0);
            end
        join_none
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_rand();
        end
        rnd_on = 0;
        wait fork;
        out_ready = 1'b1;
        err_clear = 1'b0;
        drain("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate decode path: takes instruction fields plus a full 32-bit signed immediate and packs them into a legal RV32I instruction word.
- Scatters immediate bits per format (I/S/B/U/J) and range-checks the immediate.
- Two-stage valid/ready pipeline; feeds the instruction-memory loader and the test-program generator.

Parameters:
CNT_W, 16, width of the encoded-instruction counter
NOP_INST, 32'h00000013, word emitted in place of a rejected request (ADDI x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous reset, active-low (asserted when 0)
in_valid  input  1  request present
in_ready  output  1  request accepted when in_valid&&in_ready
in_opcode  input  7  opcode field
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7, R-type only
in_imm  input  32  signed immediate; for U-type, the full upper value
out_valid  output  1  encoded word present
out_ready  input  1  consumer takes word when out_valid&&out_ready
out_inst  output  32  encoded instruction
out_err  output  1  this word was rejected (out_inst==NOP_INST)
err_clear  input  1  clears err_sticky
err_sticky  output  1  set on any rejected word leaving stage 2
enc_count  output  CNT_W  count of words handed off with out_err=0

Behaviour:
- Reset (reset==0 at a clock edge): both stage valids=0, out_inst=0, out_err=0, err_sticky=0, enc_count=0. Reset mid-transfer drops in-flight words with no output.
- Format classification:
  - I: ARITHMETIC_IMM 0010011, LOAD 0000011, JALR 1100111
  - S: STORE 0100011
  - B: BRANCH 1100011
  - U: LUI 0110111, AUIPC 0010111
  - J: JAL 1101111
  - R: 0110011, no immediate; uses funct7
  - Any other opcode: rejected
- Stage 1 (on accept):
  - Register the fields and the format.
  - Compute range_ok:
    - I/S: -2048..2047
    - B: -4096..4094 and imm[0]==0
    - J: -1048576..1048574 and imm[0]==0
    - U: imm[11:0]==0
    - R: always ok
- Stage 2 (combinational from the stage-1 registers, registered on advance):
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  - R: {f7,rs2,rs1,f3,rd,op}
  - Rejected (bad opcode or !range_ok): out_inst=NOP_INST, out_err=1.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = (s1 advances), combinational.
  - Latency 2 cycles from accept to out_valid with out_ready held 1. Throughput 1 word/cycle.
  - out_valid/out_inst/out_err stay stable while out_valid&&!out_ready.
  - Order is preserved; no drops or duplicates.
- Counters and error flag:
  - enc_count increments on each handoff with out_err=0. It wraps modulo 2^CNT_W.
  - err_sticky sets on handoff with out_err=1.
  - If err_clear and a set event occur in the same cycle, set wins.
- Back-to-back accept, advance and handoff in the same cycle is legal. Full pipeline stalled: in_ready=0.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: range and alignment checks as above; out-of-range requests are rejected to NOP_INST with out_err=1.
- Undefined: range_ok forced 1 for all supported formats. Immediates are silently truncated to the format's bits; imm[0] is ignored for B/J and imm[11:0] for U. Only unsupported opcodes raise out_err.

Test Plan:
- ADDI x1,x0,-1 (op 0010011, rd 1, f3 0, imm 0xFFFFFFFF), out_ready=1 -> out_inst=0xFFF00093 two cycles after accept, out_err=0, enc_count=1.
- SW x5,8(x2) (op 0100011, rs1 2, rs2 5, f3 010, imm 8) -> 0x00512423; BEQ x1,x2,-4 (op 1100011, rs1 1, rs2 2, imm -4) -> 0xFE208EE3.
- JAL x1,+2048 (op 1101111, rd 1, imm 0x800) -> 0x001000EF; LUI x3,0x12345000 -> 0x123451B7.
- ADDI imm=2048 with IMM_RANGE_CHECK_EN defined -> out_inst=0x00000013, out_err=1, err_sticky=1, enc_count unchanged. Without the macro -> 0x80000093, out_err=0.
- Stream of 4 requests with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts. out_inst held stable; on release, all 4 words emerge in order with no loss.
- Reset=0 asserted with 2 words in flight -> next cycle out_valid=0, enc_count=0, err_sticky=0; first post-reset request emerges after 2 cycles.
